maj_selfcheck_engine: RTL

Parametrised stimulus-generator and checker for N-input threshold/majority DUTs. Drives a vector onto the DUT each cycle, exhaustive or LFSR-random, and computes the popcount reference internally. It compares the reference against the DUT output after a configurable pipeline latency and records mismatch count and first failing vector. It sits beside mapped majority netlists in FPGA/emulation self-test, where exhaustive simulation of wide inputs (e.g. 2^39 vectors) is infeasible.

---
 rtl/maj_selfcheck_engine.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/maj_selfcheck_engine.sv
// Stimulus generator and popcount-reference checker for N-input threshold/majority DUTs.
// Drives exhaustive or LFSR vectors, compares dut_y against a LAT-delayed reference.
module maj_selfcheck_engine #(
    parameter int          N      = 39,
    parameter int          THRESH = (N + 1) / 2,
    parameter int          LAT    = 0,
    parameter int          CNT_W  = 16,
    parameter logic [N-1:0] TAPS  = N'(39'h40_0000_0004)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N-1:0]     seed,
    input  logic [N:0]       num_vec,
    output logic [N-1:0]     stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [N-1:0]     first_fail,
    output logic             first_fail_valid
);
    localparam int PC_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state, state_nxt;
    logic       mode_q;
    logic [N:0] rem;

    logic         vld_p0, y_ref_p0;
    logic         vld_cmp, y_ref_cmp, pipe_busy;
    logic [N-1:0] stim_cmp;

    function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] v);
        return {v[N-2:0], ^(v & TAPS)};
    endfunction

    // Stage p0: reference computed straight off the registered stimulus
    assign vld_p0   = (state == RUN);
    assign y_ref_p0 = int'(popcount(stim)) >= THRESH;

    generate
        if (LAT == 0) begin : g_comb
            assign vld_cmp   = vld_p0;
            assign y_ref_cmp = y_ref_p0;
            assign stim_cmp  = stim;
            assign pipe_busy = vld_p0;
        end else begin : g_pipe
            logic [LAT-1:0] vld_pl;
            logic [LAT-1:0] y_ref_pl;
            logic [N-1:0]   stim_pl [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pl <= '0;
                end else begin
                    vld_pl[0] <= vld_p0;
                    for (int i = 1; i < LAT; i++) vld_pl[i] <= vld_pl[i-1];
                end
            end

            // Data stages carry no reset; only the valid marks them meaningful
            always_ff @(posedge clk) begin
                y_ref_pl[0] <= y_ref_p0;
                stim_pl[0]  <= stim;
                for (int i = 1; i < LAT; i++) begin
                    y_ref_pl[i] <= y_ref_pl[i-1];
                    stim_pl[i]  <= stim_pl[i-1];
                end
            end

            assign vld_cmp   = vld_pl[LAT-1];
            assign y_ref_cmp = y_ref_pl[LAT-1];
            assign stim_cmp  = stim_pl[LAT-1];
            assign pipe_busy = vld_p0 | (|vld_pl);
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = (num_vec == '0) ? DRAIN : RUN;
            RUN:     if (rem == (N+1)'(1)) state_nxt = DRAIN;
            DRAIN:   if (!pipe_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            mode_q           <= 1'b0;
            rem              <= '0;
            stim             <= '0;
            done             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                mode_q           <= mode;
                rem              <= num_vec;
                done             <= 1'b0;
                mismatch_cnt     <= '0;
                first_fail       <= '0;
                first_fail_valid <= 1'b0;
                if (num_vec != '0)
                    stim <= mode ? ((seed == '0) ? N'(1) : seed) : '0;
            end else begin
                // The last vector stays on stim through DRAIN and IDLE
                if (state == RUN) begin
                    rem <= rem - (N+1)'(1);
                    if (rem != (N+1)'(1))
                        stim <= mode_q ? lfsr_next(stim) : stim + N'(1);
                end
                if (vld_cmp && (dut_y != y_ref_cmp)) begin
                    mismatch_cnt <= sat_inc(mismatch_cnt);
                    if (!first_fail_valid) begin
                        first_fail       <= stim_cmp;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (state == DRAIN && !pipe_busy) done <= 1'b1;
            end
        end
    end
endmodule
